// File: rtl/rtrt_fixed_pkg.sv
// rtl/rtrt_fixed_pkg.sv - fixed-point types, limits and dot-product FSM states for the tracer core
package rtrt_fixed_pkg;

  localparam int FIXED_W   = 64;
  localparam int FRAC_BITS = 32;
  localparam int MUL_W     = 128;
  // Three 128-bit products summed need two extra bits of headroom.
  localparam int ACC_W     = 130;

  typedef logic signed [FIXED_W-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = {1'b0, {(FIXED_W-1){1'b1}}};
  localparam fixed_t FIXED_MIN = {1'b1, {(FIXED_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT, ACCUM, DONE} dot_state_e;

endpackage

// File: rtl/fixed_sat_shift.sv
// rtl/fixed_sat_shift.sv - rescale a wide signed accumulator to fixed_t with saturation
module fixed_sat_shift
  import rtrt_fixed_pkg::*;
#(
  parameter int FRAC = FRAC_BITS
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output fixed_t                  o_dot,
  output logic                    o_sat
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(FIXED_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(FIXED_MIN);

  // Arithmetic shift floors toward -inf, matching the tracer's rounding.
  logic signed [ACC_W-1:0] w_r;
  assign w_r = i_acc >>> FRAC;

  always_comb begin
    o_dot = w_r[FIXED_W-1:0];
    o_sat = 1'b0;
    if (w_r > HI) begin
      o_dot = FIXED_MAX;
      o_sat = 1'b1;
    end else if (w_r < LO) begin
      o_dot = FIXED_MIN;
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/dot3_mul_sequencer.sv
// rtl/dot3_mul_sequencer.sv - sequences three products through the shared multiplier into a saturated dot
module dot3_mul_sequencer
  import rtrt_fixed_pkg::*;
#(
  parameter int W           = FIXED_W,
  parameter int FRAC        = FRAC_BITS,
  parameter int MUL_LATENCY = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*W-1:0]     in_a,
  input  logic [3*W-1:0]     in_b,
  output logic [MUL_W-1:0]   mul_a,
  output logic [MUL_W-1:0]   mul_b,
  input  logic [MUL_W-1:0]   mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_dot,
  output logic               out_sat
);

  localparam int              CNT_W    = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

  function automatic logic [MUL_W-1:0] sext(input logic [W-1:0] c);
    return {{(MUL_W-W){c[W-1]}}, c};
  endfunction

  dot_state_e         r_state;
  logic [2*W-1:0]     r_a;
  logic [2*W-1:0]     r_b;
  logic [1:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [MUL_W-1:0]   r_mul_a;
  logic [MUL_W-1:0]   r_mul_b;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [W-1:0]       r_out_dot;
  logic               r_out_sat;

  logic [ACC_W-1:0]   w_acc_next;
  logic [W-1:0]       w_dot;
  logic               w_sat;

  assign w_acc_next = r_acc + {{(ACC_W-MUL_W){mul_p[MUL_W-1]}}, mul_p};

  // Final result is taken from the accumulator value being written on the last ACCUM.
  fixed_sat_shift #(.FRAC(FRAC)) u_sat (
    .i_acc (w_acc_next),
    .o_dot (w_dot),
    .o_sat (w_sat)
  );

  // Only y and z are kept; x goes straight to the multiplier on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_dot   <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_in_ready) begin
            r_in_ready <= 1'b1;
          end else if (in_valid) begin
            r_a        <= in_a[3*W-1:W];
            r_b        <= in_b[3*W-1:W];
            r_mul_a    <= sext(in_a[W-1:0]);
            r_mul_b    <= sext(in_b[W-1:0]);
            r_acc      <= '0;
            r_idx      <= '0;
            r_cnt      <= CNT_LOAD;
            r_in_ready <= 1'b0;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= ACCUM;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ACCUM: begin
          r_acc <= w_acc_next;
          if (r_idx != 2'd2) begin
            r_idx   <= r_idx + 1'b1;
            r_mul_a <= sext((r_idx == 2'd0) ? r_a[W-1:0] : r_a[2*W-1:W]);
            r_mul_b <= sext((r_idx == 2'd0) ? r_b[W-1:0] : r_b[2*W-1:W]);
            r_cnt   <= CNT_LOAD;
            r_state <= WAIT;
          end else begin
            r_out_dot   <= w_dot;
            r_out_sat   <= w_sat;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_valid = r_out_valid;
  assign out_dot   = r_out_dot;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_dot3_mul_sequencer.sv
// tb/tb_dot3_mul_sequencer.sv - randomized and directed bench for dot3_mul_sequencer
module tb_dot3_mul_sequencer;

  localparam int ML      = 32;
  localparam int MUL_LAT = 16;
  localparam int EXP_LAT = 3 * (ML + 1);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [191:0] in_a = '0;
  logic [191:0] in_b = '0;
  logic [127:0] mul_a;
  logic [127:0] mul_b;
  logic [127:0] mul_p;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [63:0]  out_dot;
  logic         out_sat;

  int n_checks = 0;
  int n_pass   = 0;

  dot3_mul_sequencer #(.W(64), .FRAC(32), .MUL_LATENCY(ML)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dot   (out_dot),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: product appears MUL_LAT cycles after the operands.
  logic [127:0] pipe [MUL_LAT];
  always @(posedge clk) begin
    pipe[0] <= mul_a * mul_b;
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_p = pipe[MUL_LAT-1];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void ref_dot(input logic [191:0] a, input logic [191:0] b,
                                  output logic [63:0] d, output logic s);
    logic signed [191:0] acc, ea, eb, r, hi, lo;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      ea = $signed(a[i*64 +: 64]);
      eb = $signed(b[i*64 +: 64]);
      acc = acc + ea * eb;
    end
    r  = acc >>> 32;
    hi = 192'sh7FFF_FFFF_FFFF_FFFF;
    lo = -hi - 192'sd1;
    s  = 1'b1;
    if (r > hi)      d = 64'h7FFF_FFFF_FFFF_FFFF;
    else if (r < lo) d = 64'h8000_0000_0000_0000;
    else begin
      d = r[63:0];
      s = 1'b0;
    end
  endfunction

  function automatic logic [191:0] rand_vec(input bit wide);
    logic [191:0] v;
    logic [63:0]  r;
    for (int i = 0; i < 3; i++) begin
      r = {$urandom, $urandom};
      v[i*64 +: 64] = wide ? r : {{24{r[39]}}, r[39:0]};
    end
    return v;
  endfunction

  function automatic logic [127:0] sx(input logic [63:0] c);
    return {{64{c[63]}}, c};
  endfunction

  task automatic send(input logic [191:0] a, input logic [191:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 128'(in_ready), 128'd1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [191:0] a, input logic [191:0] b,
                        input logic [63:0] exp_dot, input logic exp_sat, input int hold);
    int n, chg;
    logic [127:0] prev;
    send(a, b);
    prev = mul_a;
    n = 0;
    chg = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({tag, "_mula_x"}, mul_a, sx(a[63:0]));
        check({tag, "_mulb_x"}, mul_b, sx(b[63:0]));
      end
      if (mul_a != prev) chg++;
      prev = mul_a;
    end
    check({tag, "_valid_seen"}, 128'(out_valid), 128'd1);
    check({tag, "_latency"}, 128'(n - 1), 128'(EXP_LAT));
    check({tag, "_mula_steps"}, 128'(chg), 128'(((a[63:0] != a[127:64]) ? 1 : 0) +
                                               ((a[127:64] != a[191:128]) ? 1 : 0)));
    check({tag, "_mulb_z"}, mul_b, sx(b[191:128]));
    check({tag, "_dot"}, 128'(out_dot), 128'(exp_dot));
    check({tag, "_sat"}, 128'(out_sat), 128'(exp_sat));
    for (int i = 0; i < hold; i++) begin
      in_a = rand_vec(1'b0);
      in_b = rand_vec(1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hold_dot"}, 128'(out_dot), 128'(exp_dot));
      check({tag, "_hold_ready"}, 128'(in_ready), 128'd0);
      check({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
    check({tag, "_ready_back"}, 128'(in_ready), 128'd1);
  endtask

  logic [191:0] ra, rb;
  logic [63:0]  rd;
  logic         rs;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_dot", 128'(out_dot), 128'd0);
    check("rst_out_sat", 128'(out_sat), 128'd0);
    check("rst_mul_a", mul_a, 128'd0);
    check("rst_mul_b", mul_b, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 128'(in_ready), 128'd1);

    run_op("int123",
           {64'h3_0000_0000, 64'h2_0000_0000, 64'h1_0000_0000},
           {64'h6_0000_0000, 64'h5_0000_0000, 64'h4_0000_0000},
           64'h0000_0020_0000_0000, 1'b0, 0);
    run_op("neg15", {64'd0, 64'd0, 64'hFFFF_FFFE_8000_0000}, {64'd0, 64'd0, 64'h2_0000_0000},
           64'hFFFF_FFFD_0000_0000, 1'b0, 0);
    run_op("sat_max", {3{64'h7FFF_FFFF_FFFF_FFFF}}, {3{64'h7FFF_FFFF_FFFF_FFFF}},
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0);
    run_op("sat_min", {3{64'h7FFF_FFFF_FFFF_FFFF}}, {3{64'h8000_0000_0000_0000}},
           64'h8000_0000_0000_0000, 1'b1, 0);

    ra = rand_vec(1'b0);
    rb = rand_vec(1'b0);
    ref_dot(ra, rb, rd, rs);
    out_ready = 1'b0;
    run_op("hold", ra, rb, rd, rs, 20);

    send(rand_vec(1'b0), rand_vec(1'b0));
    repeat (50) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_in_ready", 128'(in_ready), 128'd0);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_out_dot", 128'(out_dot), 128'd0);
    check("abort_mul_a", mul_a, 128'd0);
    check("abort_mul_b", mul_b, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("after_abort", {64'd0, 64'd0, 64'h1_0000_0000}, {64'd0, 64'd0, 64'h1_0000_0000},
           64'h0000_0001_0000_0000, 1'b0, 0);

    for (int k = 0; k < 12; k++) begin
      ra = rand_vec(k[0]);
      rb = rand_vec(k[1]);
      ref_dot(ra, rb, rd, rs);
      run_op($sformatf("rnd%0d", k), ra, rb, rd, rs, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
